// File: rtl/alu_exec_unit_if.sv
// Issue and writeback bundle between the reservation stations, the ALU execution unit and the CDB arbiter.
// The master modport is the RS/arbiter side; the slave modport is the execution unit.
interface alu_exec_unit_if #(
    parameter int DATA_W = 32,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 4
);
    logic              flush;
    logic              issue_en;
    logic              eu_ready;
    logic [3:0]        iss_alu_op;
    logic              iss_alu_src;
    logic [DATA_W-1:0] iss_rs1_val;
    logic [DATA_W-1:0] iss_rs2_val;
    logic [DATA_W-1:0] iss_imm;
    logic [PREG_W-1:0] iss_prd;
    logic              iss_reg_write;
    logic [ROB_W-1:0]  iss_rob_tag;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [PREG_W-1:0] wb_prd_out;
    logic [ROB_W-1:0]  wb_rob_tag;
    logic              wb_reg_write;
    logic              wb_en;
    logic [PREG_W-1:0] wb_prd;

    modport master (
        output flush, issue_en, iss_alu_op, iss_alu_src, iss_rs1_val, iss_rs2_val,
               iss_imm, iss_prd, iss_reg_write, iss_rob_tag, wb_ready,
        input  eu_ready, wb_valid, wb_data, wb_prd_out, wb_rob_tag, wb_reg_write,
               wb_en, wb_prd
    );

    modport slave (
        input  flush, issue_en, iss_alu_op, iss_alu_src, iss_rs1_val, iss_rs2_val,
               iss_imm, iss_prd, iss_reg_write, iss_rob_tag, wb_ready,
        output eu_ready, wb_valid, wb_data, wb_prd_out, wb_rob_tag, wb_reg_write,
               wb_en, wb_prd
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: accepts issued ops, computes a 1-cycle ALU result and holds it until the CDB arbiter takes it.
// Define ALU_EXEC_MUL_EN to build the MUL_LAT-cycle multiplier for op 10; otherwise op 10 returns 0 in one cycle.
module alu_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int PREG_W  = 6,
    parameter int ROB_W   = 4,
    parameter int MUL_LAT = 4
) (
    input logic            clk,
    input logic            rst,
    alu_exec_unit_if.slave eu
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [PREG_W-1:0] wb_prd_q, wb_prd_d;
    logic [ROB_W-1:0]  wb_rob_q, wb_rob_d;
    logic              wb_regw_q, wb_regw_d;

    logic              eu_ready;
    logic              wb_valid;
    logic              accept;
    logic [DATA_W-1:0] operand_b;
    logic [DATA_W-1:0] alu_result;
    logic [4:0]        shamt;

`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd10;

    logic [DATA_W-1:0] mul_a_q, mul_a_d;
    logic [DATA_W-1:0] mul_b_q, mul_b_d;
    logic [3:0]        cnt_q, cnt_d;
`endif

    assign operand_b = eu.iss_alu_src ? eu.iss_imm : eu.iss_rs2_val;
    assign shamt     = operand_b[4:0];
    assign wb_valid  = (state_q == DONE);
    assign eu_ready  = (state_q == IDLE) || ((state_q == DONE) && eu.wb_ready);
    assign accept    = eu.issue_en && eu_ready;

    assign eu.eu_ready     = eu_ready;
    assign eu.wb_valid     = wb_valid;
    assign eu.wb_data      = wb_data_q;
    assign eu.wb_prd_out   = wb_prd_q;
    assign eu.wb_rob_tag   = wb_rob_q;
    assign eu.wb_reg_write = wb_regw_q;
    assign eu.wb_en        = wb_valid && eu.wb_ready && wb_regw_q;
    assign eu.wb_prd       = wb_prd_q;

    // Undefined op codes, and MUL when no multiplier is built, fall through to a zero result.
    always_comb begin
        alu_result = '0;
        case (eu.iss_alu_op)
            OP_ADD:  alu_result = eu.iss_rs1_val + operand_b;
            OP_SUB:  alu_result = eu.iss_rs1_val - operand_b;
            OP_AND:  alu_result = eu.iss_rs1_val & operand_b;
            OP_OR:   alu_result = eu.iss_rs1_val | operand_b;
            OP_XOR:  alu_result = eu.iss_rs1_val ^ operand_b;
            OP_SLL:  alu_result = eu.iss_rs1_val << shamt;
            OP_SRL:  alu_result = eu.iss_rs1_val >> shamt;
            OP_SRA:  alu_result = $signed(eu.iss_rs1_val) >>> shamt;
            OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(eu.iss_rs1_val) < $signed(operand_b))};
            OP_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (eu.iss_rs1_val < operand_b)};
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wb_data_d = wb_data_q;
        wb_prd_d  = wb_prd_q;
        wb_rob_d  = wb_rob_q;
        wb_regw_d = wb_regw_q;
`ifdef ALU_EXEC_MUL_EN
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
`ifdef ALU_EXEC_MUL_EN
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    wb_data_d = mul_a_q * mul_b_q;
                    state_d   = DONE;
                end
            end
`endif
            DONE: if (eu.wb_ready && !accept) state_d = IDLE;
            default: ;
        endcase

        if (accept) begin
            wb_prd_d  = eu.iss_prd;
            wb_rob_d  = eu.iss_rob_tag;
            wb_regw_d = eu.iss_reg_write;
            wb_data_d = alu_result;
            state_d   = DONE;
`ifdef ALU_EXEC_MUL_EN
            // BUSY lasts MUL_LAT-1 cycles so the product shows up MUL_LAT cycles after accept.
            if (eu.iss_alu_op == OP_MUL) begin
                mul_a_d = eu.iss_rs1_val;
                mul_b_d = operand_b;
                cnt_d   = 4'(MUL_LAT - 1);
                state_d = BUSY;
            end
`endif
        end

        if (eu.flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wb_data_q <= '0;
            wb_prd_q  <= '0;
            wb_rob_q  <= '0;
            wb_regw_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wb_data_q <= wb_data_d;
            wb_prd_q  <= wb_prd_d;
            wb_rob_q  <= wb_rob_d;
            wb_regw_q <= wb_regw_d;
`ifdef ALU_EXEC_MUL_EN
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            cnt_q     <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table, hand-written corner sequences and a random run
// compared every cycle against a behavioural model of the unit's result and timing.
module tb_alu_exec_unit;
    localparam int DATA_W  = 32;
    localparam int PREG_W  = 6;
    localparam int ROB_W   = 4;
    localparam int MUL_LAT = 4;

    typedef struct {
        logic        ien;
        logic [3:0]  op;
        logic        src;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [5:0]  prd;
        logic        regw;
        logic [3:0]  rob;
        logic        wbr;
        logic        fl;
        logic        rs;
    } stim_t;

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference model: whether a result is held, cycles left until a pending multiply shows up, and the held result.
    bit          m_valid = 1'b0;
    int          m_busy  = 0;
    logic [31:0] m_data  = '0;
    logic [5:0]  m_prd   = '0;
    logic [3:0]  m_rob   = '0;
    logic        m_regw  = 1'b0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.DATA_W(DATA_W), .PREG_W(PREG_W), .ROB_W(ROB_W)) eu_if ();

    alu_exec_unit #(
        .DATA_W (DATA_W),
        .PREG_W (PREG_W),
        .ROB_W  (ROB_W),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .eu (eu_if)
    );

    function automatic bit isMul(input logic [3:0] op);
`ifdef ALU_EXEC_MUL_EN
        return (op == 4'd10);
`else
        return (op == 4'd15) && (op == 4'd10);
`endif
    endfunction

    function automatic logic [31:0] refResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] fill;
        sh   = int'(b[4:0]);
        fill = 32'hFFFF_FFFF;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return (a >> sh) | (a[31] ? ~(fill >> sh) : 32'h0);
            4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_EXEC_MUL_EN
            4'd10: begin
                longint unsigned p;
                p = longint'(a) * longint'(b);
                return p[31:0];
            end
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic stim_t mkStim(input logic ien, input logic [3:0] op, input logic src,
                                     input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                                     input logic [5:0] prd, input logic regw, input logic [3:0] rob,
                                     input logic wbr, input logic fl, input logic rs);
        stim_t s;
        s.ien = ien; s.op = op; s.src = src; s.rs1 = rs1; s.rs2 = rs2; s.imm = imm;
        s.prd = prd; s.regw = regw; s.rob = rob; s.wbr = wbr; s.fl = fl; s.rs = rs;
        return s;
    endfunction

    function automatic stim_t idle(input logic wbr);
        return mkStim(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 6'd0, 1'b0, 4'd0, wbr, 1'b0, 1'b0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Compares the DUT against the model for the current cycle, then advances the model across the next edge.
    task automatic checkModel(input stim_t s);
        bit exp_ready;
        bit accepted;
        exp_ready = (m_busy == 0) && (!m_valid || s.wbr);
        checkOutput("eu_ready", 32'(eu_if.eu_ready), 32'(exp_ready));
        checkOutput("wb_valid", 32'(eu_if.wb_valid), 32'(m_valid));
        checkOutput("wb_en", 32'(eu_if.wb_en), 32'(m_valid && s.wbr && m_regw));
        if (m_valid) begin
            checkOutput("wb_data", eu_if.wb_data, m_data);
            checkOutput("wb_prd_out", 32'(eu_if.wb_prd_out), 32'(m_prd));
            checkOutput("wb_prd", 32'(eu_if.wb_prd), 32'(m_prd));
            checkOutput("wb_rob_tag", 32'(eu_if.wb_rob_tag), 32'(m_rob));
            checkOutput("wb_reg_write", 32'(eu_if.wb_reg_write), 32'(m_regw));
        end

        accepted = s.ien && exp_ready;
        if (s.rs || s.fl) begin
            m_valid = 1'b0;
            m_busy  = 0;
            if (s.rs) begin
                m_data = '0; m_prd = '0; m_rob = '0; m_regw = 1'b0;
            end
        end else begin
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_valid = 1'b1;
            end else if (m_valid && s.wbr) begin
                m_valid = 1'b0;
            end
            if (accepted) begin
                m_data = refResult(s.op, s.rs1, s.src ? s.imm : s.rs2);
                m_prd  = s.prd;
                m_rob  = s.rob;
                m_regw = s.regw;
                if (isMul(s.op)) begin
                    m_busy  = MUL_LAT - 1;
                    m_valid = 1'b0;
                end else begin
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        rst                 = s.rs;
        eu_if.flush         = s.fl;
        eu_if.issue_en      = s.ien;
        eu_if.iss_alu_op    = s.op;
        eu_if.iss_alu_src   = s.src;
        eu_if.iss_rs1_val   = s.rs1;
        eu_if.iss_rs2_val   = s.rs2;
        eu_if.iss_imm       = s.imm;
        eu_if.iss_prd       = s.prd;
        eu_if.iss_reg_write = s.regw;
        eu_if.iss_rob_tag   = s.rob;
        eu_if.wb_ready      = s.wbr;
        #1;
        checkModel(s);
    endtask

    initial begin
        vec_t  tbl[12];
        stim_t r;

        tbl[0]  = '{4'd0,  1'b1, 32'd5,          32'd0,          32'hFFFF_FFFD, 32'd2};
        tbl[1]  = '{4'd1,  1'b0, 32'd1,          32'd2,          32'd0,         32'hFFFF_FFFF};
        tbl[2]  = '{4'd7,  1'b0, 32'h8000_0000,  32'd4,          32'd0,         32'hF800_0000};
        tbl[3]  = '{4'd9,  1'b0, 32'd1,          32'hFFFF_FFFF,  32'd0,         32'd1};
        tbl[4]  = '{4'd2,  1'b0, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'd0,         32'h00F0_1234};
        tbl[5]  = '{4'd3,  1'b1, 32'hF000_0000,  32'd0,          32'h0000_000F, 32'hF000_000F};
        tbl[6]  = '{4'd4,  1'b0, 32'h0000_00F0,  32'h0000_00FF,  32'd0,         32'h0000_000F};
        tbl[7]  = '{4'd5,  1'b0, 32'd1,          32'd33,         32'd0,         32'd2};
        tbl[8]  = '{4'd6,  1'b0, 32'h8000_0000,  32'd31,         32'd0,         32'd1};
        tbl[9]  = '{4'd8,  1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,         32'd1};
        tbl[10] = '{4'd8,  1'b1, 32'd5,          32'd0,          32'hFFFF_FFFE, 32'd0};
        tbl[11] = '{4'd13, 1'b0, 32'd5,          32'd6,          32'd0,         32'd0};

        eu_if.flush = 1'b0; eu_if.issue_en = 1'b0; eu_if.iss_alu_op = '0; eu_if.iss_alu_src = 1'b0;
        eu_if.iss_rs1_val = '0; eu_if.iss_rs2_val = '0; eu_if.iss_imm = '0; eu_if.iss_prd = '0;
        eu_if.iss_reg_write = 1'b0; eu_if.iss_rob_tag = '0; eu_if.wb_ready = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state.
        applyStimulus(mkStim(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 6'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
        applyStimulus(idle(1'b0));
        checkOutput("rst_valid", 32'(eu_if.wb_valid), 32'd0);
        checkOutput("rst_en", 32'(eu_if.wb_en), 32'd0);
        checkOutput("rst_ready", 32'(eu_if.eu_ready), 32'd1);
        checkOutput("rst_data", eu_if.wb_data, 32'd0);
        checkOutput("rst_rob", 32'(eu_if.wb_rob_tag), 32'd0);

        // Vector table, issued back to back with the arbiter always ready.
        for (int i = 0; i <= 12; i++) begin
            if (i < 12)
                applyStimulus(mkStim(1'b1, tbl[i].op, tbl[i].src, tbl[i].rs1, tbl[i].rs2, tbl[i].imm,
                                     6'(i + 1), 1'(i != 5), 4'(i), 1'b1, 1'b0, 1'b0));
            else
                applyStimulus(idle(1'b1));
            if (i > 0) begin
                checkOutput("vec_valid", 32'(eu_if.wb_valid), 32'd1);
                checkOutput("vec_data", eu_if.wb_data, tbl[i-1].exp);
                checkOutput("vec_ready", 32'(eu_if.eu_ready), 32'd1);
            end
        end
        applyStimulus(idle(1'b1));

        // ADD with immediate and wakeup.
        applyStimulus(mkStim(1'b1, 4'd0, 1'b1, 32'd5, 32'd99, 32'hFFFF_FFFD, 6'd7, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0));
        applyStimulus(idle(1'b1));
        checkOutput("add_valid", 32'(eu_if.wb_valid), 32'd1);
        checkOutput("add_data", eu_if.wb_data, 32'd2);
        checkOutput("add_en", 32'(eu_if.wb_en), 32'd1);
        checkOutput("add_prd", 32'(eu_if.wb_prd), 32'd7);
        checkOutput("add_rob", 32'(eu_if.wb_rob_tag), 32'd2);
        applyStimulus(idle(1'b1));

        // Arbiter stall: result held, issue ignored.
        applyStimulus(mkStim(1'b1, 4'd4, 1'b0, 32'h0F0, 32'h0FF, 32'd0, 6'd3, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mkStim(1'b1, 4'd0, 1'b0, 32'd100, 32'd1, 32'd0, 6'd9, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0));
            checkOutput("stall_data", eu_if.wb_data, 32'h0000_000F);
            checkOutput("stall_ready", 32'(eu_if.eu_ready), 32'd0);
            checkOutput("stall_en", 32'(eu_if.wb_en), 32'd0);
        end
        applyStimulus(idle(1'b1));
        checkOutput("stall_rel_en", 32'(eu_if.wb_en), 32'd1);
        checkOutput("stall_rel_rob", 32'(eu_if.wb_rob_tag), 32'd5);
        applyStimulus(idle(1'b1));
        checkOutput("stall_no_capture", 32'(eu_if.wb_valid), 32'd0);

        // MUL 7*6.
        applyStimulus(mkStim(1'b1, 4'd10, 1'b0, 32'd7, 32'd6, 32'd0, 6'd4, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0));
`ifdef ALU_EXEC_MUL_EN
        for (int k = 1; k < MUL_LAT; k++) begin
            applyStimulus(idle(1'b1));
            checkOutput("mul_busy_ready", 32'(eu_if.eu_ready), 32'd0);
            checkOutput("mul_busy_valid", 32'(eu_if.wb_valid), 32'd0);
        end
        applyStimulus(idle(1'b1));
        checkOutput("mul_valid", 32'(eu_if.wb_valid), 32'd1);
        checkOutput("mul_data", eu_if.wb_data, 32'd42);
`else
        applyStimulus(idle(1'b1));
        checkOutput("mul_valid", 32'(eu_if.wb_valid), 32'd1);
        checkOutput("mul_data", eu_if.wb_data, 32'd0);
`endif
        applyStimulus(idle(1'b1));

        // Flush while a multiply is in flight: it must never complete.
        applyStimulus(mkStim(1'b1, 4'd10, 1'b0, 32'd3, 32'd3, 32'd0, 6'd5, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0));
        applyStimulus(mkStim(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 6'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < MUL_LAT; k++) begin
            applyStimulus(idle(1'b1));
            checkOutput("flush_busy_valid", 32'(eu_if.wb_valid), 32'd0);
            checkOutput("flush_busy_en", 32'(eu_if.wb_en), 32'd0);
            checkOutput("flush_busy_ready", 32'(eu_if.eu_ready), 32'd1);
        end

        // Flush a held result while the arbiter stalls, then flush overriding an accept.
        applyStimulus(mkStim(1'b1, 4'd0, 1'b0, 32'd10, 32'd20, 32'd0, 6'd8, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0));
        applyStimulus(mkStim(1'b1, 4'd0, 1'b0, 32'd1, 32'd1, 32'd0, 6'd8, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0));
        applyStimulus(mkStim(1'b1, 4'd1, 1'b0, 32'd9, 32'd1, 32'd0, 6'd2, 1'b1, 4'd4, 1'b1, 1'b1, 1'b0));
        checkOutput("flush_done_valid", 32'(eu_if.wb_valid), 32'd0);
        checkOutput("flush_done_ready", 32'(eu_if.eu_ready), 32'd1);
        applyStimulus(mkStim(1'b1, 4'd0, 1'b0, 32'd3, 32'd4, 32'd0, 6'd6, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0));
        checkOutput("flush_accept_dropped", 32'(eu_if.wb_valid), 32'd0);
        applyStimulus(idle(1'b1));
        checkOutput("post_flush_data", eu_if.wb_data, 32'd7);
        checkOutput("post_flush_en", 32'(eu_if.wb_en), 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            r.ien  = ($urandom_range(0, 9) < 7);
            r.op   = ($urandom_range(0, 4) == 0) ? 4'd10 : 4'($urandom_range(0, 15));
            r.src  = 1'($urandom_range(0, 1));
            r.rs1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            r.rs2  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            r.imm  = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 64)) - 32) : 32'($urandom);
            r.prd  = 6'($urandom_range(0, 63));
            r.regw = ($urandom_range(0, 3) != 0);
            r.rob  = 4'($urandom_range(0, 15));
            r.wbr  = ($urandom_range(0, 9) < 6);
            r.fl   = ($urandom_range(0, 39) == 0);
            r.rs   = ($urandom_range(0, 149) == 0);
            applyStimulus(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-unit end of the reservation-station issue interface.
- Accepts one issued entry per handshake, plus its operand values from the register-file read. Computes the result with a 1-cycle ALU path or a multi-cycle multiply path.
- Holds the result until the completion/CDB arbiter accepts it.
- Drives the wakeup pair (wb_en, wb_prd) back to the reservation stations.

Parameters:
DATA_W, 32, operand/result width
PREG_W, 6, physical register index width
ROB_W, 4, ROB tag width
MUL_LAT, 4, multiply latency in cycles from accept to wb_valid (legal range 2..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  kill all in-flight work, synchronous
issue_en  in  1  issue request from RS
eu_ready  out  1  unit can accept this cycle
iss_alu_op  in  4  operation code
iss_alu_src  in  1  1: operand B = immediate
iss_rs1_val  in  DATA_W  operand A
iss_rs2_val  in  DATA_W  operand B when alu_src=0
iss_imm  in  DATA_W  sign-extended immediate
iss_prd  in  PREG_W  destination physical register
iss_reg_write  in  1  destination is written
iss_rob_tag  in  ROB_W  ROB tag
wb_valid  out  1  result available
wb_ready  in  1  arbiter accepts result
wb_data  out  DATA_W  result
wb_prd_out  out  PREG_W  destination of held result
wb_rob_tag  out  ROB_W  ROB tag of held result
wb_reg_write  out  1  reg_write of held result
wb_en  out  1  wakeup strobe to RS
wb_prd  out  PREG_W  wakeup tag

Behaviour:
- Reset/clock: reset rst, synchronous, active-high; clock clk.
- Reset values: state IDLE, wb_valid=0, wb_en=0. wb_data, wb_prd_out, wb_rob_tag and wb_reg_write reset to 0.
- Accept condition: issue_en && eu_ready at a rising edge. issue_en without eu_ready is ignored; no capture occurs.
- eu_ready = (state==IDLE) || (state==DONE && wb_ready). This is combinational from state and wb_ready, with no path from issue_en.
- Operand B = iss_alu_src ? iss_imm : iss_rs2_val.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is B[4:0].
  - 8 SLT (signed), 9 SLTU: result is 1/0 zero-extended.
  - 10 MUL: low DATA_W bits of the product.
  - 11-15: result 0, completes as single-cycle.
  - All arithmetic wraps modulo 2^DATA_W.
- FSM:
  - IDLE: on accept of a single-cycle op, register the result and metadata, then go to DONE. On accept of MUL, capture operands, load counter=MUL_LAT-1, then go to BUSY.
  - BUSY: counter decrements each cycle. When the counter reaches 1, the product is registered and the state goes to DONE next edge. wb_valid therefore rises exactly MUL_LAT cycles after accept. eu_ready=0 throughout BUSY.
  - DONE: wb_valid=1; outputs stay stable while wb_ready=0.
    - wb_ready=1 and a new accept: load the new op, with the same rules as IDLE. Back-to-back single-cycle ops sustain 1 result/cycle.
    - wb_ready=1 with no accept: go to IDLE.
- Latency: single-cycle op accepted at edge T gives wb_valid in cycle T+1. MUL gives wb_valid in cycle T+MUL_LAT.
- Wakeup: wb_en = wb_valid && wb_ready && wb_reg_write, and wb_prd = wb_prd_out. Both are combinational. Ops with reg_write=0 still complete via wb_valid but produce no wakeup.
- Flush: synchronous, same effect as rst on control. It overrides a simultaneous accept (the op is dropped). Asserting flush in BUSY or DONE discards the result; wb_valid=0 next cycle.
- Simultaneous rst and flush: behaves as rst.

Optional Feature:
- Macro: ALU_EXEC_MUL_EN.
- Defined: op 10 uses the MUL_LAT-cycle multiply path described above.
- Undefined:
  - No multiplier or BUSY counter logic is built.
  - Op 10 completes as a single-cycle op with result 0; state BUSY is unreachable.
  - Parameter MUL_LAT is ignored.

Test Plan:
- Reset, then idle: wb_valid=0, wb_en=0, eu_ready=1.
- ADD rs1=5, imm=-3 (alu_src=1), prd=7, reg_write=1, rob_tag=2, wb_ready=1 → next cycle: wb_valid=1, wb_data=2, wb_en=1, wb_prd=7, wb_rob_tag=2.
- Three back-to-back ops with wb_ready=1: SUB 1-2, SRA 0x80000000>>4, SLTU 1<0xFFFFFFFF → consecutive cycles: 0xFFFFFFFF, 0xF8000000, 1; eu_ready stays 1.
- wb_ready=0 for 3 cycles after XOR 0xF0^0xFF → wb_data=0x0F held stable and eu_ready=0 for those 3 cycles. An issue_en presented during the stall is not accepted.
- MUL 7*6 with MUL_LAT=4 (macro defined) → eu_ready=0 for cycles T+1..T+3; wb_valid=1 with wb_data=42 at T+4. With the macro undefined: wb_data=0 at T+1.
- flush asserted during MUL BUSY, and again in DONE with wb_ready=0 → wb_valid=0 next cycle, no wb_en pulse, eu_ready=1. A following ADD completes normally.
